// File: rtl/timer_share_arb.sv
// Shares one interval counter between NUM_REQ requesters, granting round-robin and pulsing done per interval.
// Define TIMER_ARB_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module timer_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 25
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_val,
  output logic                     led_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               led_q, led_d;
  logic [IDX_W-1:0]   win_q, win_d;

  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   len_sel;
  logic               abort;
  logic               last_cycle;

`ifdef TIMER_ARB_PRIO_EN
  // Downward scan so the lowest pending index is the last one written.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Scan from ptr+NUM_REQ down to ptr+1 so the first requester after ptr wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((state_q != COUNT) && found) begin
      ptr_d = win_idx;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        len_sel = req_len[i*CNT_W +: CNT_W];
      end
    end
  end

  assign abort      = !req[win_q];
  assign last_cycle = (cnt_q == (len_q - CNT_W'(1)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (found) state_d = COUNT;
      end
      COUNT: begin
        if (abort)           state_d = IDLE;
        else if (last_cycle) state_d = DONE;
      end
      DONE: begin
        state_d = found ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, done and led all change on the same edge as the state move, so every output is a flop.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    led_d   = led_q;
    win_d   = win_q;
    case (state_q)
      IDLE, DONE: begin
        if (found) begin
          grant_d[win_idx] = 1'b1;
          len_d            = (len_sel == '0) ? CNT_W'(1) : len_sel;
          cnt_d            = '0;
          win_d            = win_idx;
        end
      end
      COUNT: begin
        if (abort) begin
          cnt_d = '0;
        end else if (last_cycle) begin
          done_d[win_q] = 1'b1;
          led_d         = ~led_q;
          cnt_d         = '0;
        end else begin
          grant_d = grant_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= CNT_W'(1);
      led_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      led_q   <= led_d;
      win_q   <= win_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign cnt_val = cnt_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_timer_share_arb.sv
// Directed bench for timer_share_arb with NUM_REQ=4, CNT_W=8; expected values are hand-derived.
// Round-robin checks run in the default build, priority checks when TIMER_ARB_PRIO_EN is defined.
module tb_timer_share_arb;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic                     sys_clk;
  logic                     sys_rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         cnt_val;
  logic                     led_out;

  int vectors;
  int miscompares;
  logic [3:0] order [5];
  logic exp_led;
  int bad;

  timer_share_arb #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .cnt_val   (cnt_val),
    .led_out   (led_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [CNT_W-1:0] l0,
                               input logic [CNT_W-1:0] l1, input logic [CNT_W-1:0] l2,
                               input logic [CNT_W-1:0] l3);
    req     = r;
    req_len = {l3, l2, l1, l0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    req       = '0;
    sys_rst_n = 1'b0;
    #4;
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sys_rst_n   = 1'b0;
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);

    // Test 1: reset values, single interval of 5, then async reset mid-count
    #12;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", cnt_val, 0);
    checkOutput("rst_led", led_out, 0);
    sys_rst_n = 1'b1;
    tick();
    checkOutput("idle_grant", grant, 0);
    applyStimulus(4'b0001, 8'd5, 8'd0, 8'd0, 8'd0);
    tick();
    checkOutput("t1_grant_first", grant, 4'b0001);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_cnt0", cnt_val, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("t1_grant_hold", grant, 4'b0001);
      checkOutput("t1_cnt", cnt_val, i);
    end
    tick();
    checkOutput("t1_grant_off", grant, 0);
    checkOutput("t1_done", done, 4'b0001);
    checkOutput("t1_led", led_out, 1);
    checkOutput("t1_busy_done", busy, 1);
    tick();
    checkOutput("t1_regrant", grant, 4'b0001);
    checkOutput("t1_done_clear", done, 0);
    tick();
    tick();
    checkOutput("t1_cnt_mid", cnt_val, 2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t1_async_grant", grant, 0);
    checkOutput("t1_async_busy", busy, 0);
    checkOutput("t1_async_cnt", cnt_val, 0);
    checkOutput("t1_async_led", led_out, 0);
    req = '0;
    #3;
    sys_rst_n = 1'b1;
    tick();

    // Test 2: all requesting, len 3 each
`ifdef TIMER_ARB_PRIO_EN
    for (int k = 0; k < 5; k++) order[k] = 4'b0001;
`else
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
`endif
    doReset();
    exp_led = 1'b0;
    applyStimulus(4'b1111, 8'd3, 8'd3, 8'd3, 8'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("t2_grant_a", grant, order[k]);
      tick();
      tick();
      checkOutput("t2_grant_c", grant, order[k]);
      tick();
      exp_led = ~exp_led;
      checkOutput("t2_gap_grant", grant, 0);
      checkOutput("t2_done", done, order[k]);
      checkOutput("t2_led", led_out, exp_led);
    end
    req = '0;
    tick();
    checkOutput("t2_idle_grant", grant, 0);
    checkOutput("t2_idle_busy", busy, 0);
    checkOutput("t2_led_final", led_out, 1);

    // Test 3: abort requester 2 after 4 grant cycles
    doReset();
    applyStimulus(4'b0100, 8'd0, 8'd0, 8'd10, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3_grant", grant, 4'b0100);
    end
    req = '0;
    tick();
    checkOutput("t3_abort_grant", grant, 0);
    checkOutput("t3_abort_done", done, 0);
    checkOutput("t3_abort_busy", busy, 0);
    checkOutput("t3_abort_cnt", cnt_val, 0);
    checkOutput("t3_abort_led", led_out, 0);
    tick();
    checkOutput("t3_no_late_done", done, 0);
    applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
    tick();
`ifdef TIMER_ARB_PRIO_EN
    checkOutput("t3_next_winner", grant, 4'b0001);
`else
    checkOutput("t3_next_winner", grant, 4'b1000);
`endif
    tick();
    checkOutput("t3_len1_done", done != 0, 1);
    req = '0;
    tick();

    // Test 4: zero length acts as one, max length counts 255 without wrap
    doReset();
    applyStimulus(4'b0010, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkOutput("t4_zero_grant", grant, 4'b0010);
    tick();
    checkOutput("t4_zero_grant_off", grant, 0);
    checkOutput("t4_zero_done", done, 4'b0010);
    checkOutput("t4_zero_led", led_out, 1);
    req = '0;
    tick();
    applyStimulus(4'b0010, 8'd0, 8'd255, 8'd0, 8'd0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (grant !== 4'b0010 || cnt_val !== 8'(i)) bad++;
    end
    checkOutput("t4_max_run", bad, 0);
    checkOutput("t4_max_peak", cnt_val, 254);
    tick();
    checkOutput("t4_max_grant_off", grant, 0);
    checkOutput("t4_max_done", done, 4'b0010);
    checkOutput("t4_max_cnt", cnt_val, 0);
    checkOutput("t4_max_led", led_out, 0);
    req = '0;
    tick();

    // Test 5: late request and len change mid-interval
    doReset();
    applyStimulus(4'b0001, 8'd6, 8'd2, 8'd0, 8'd0);
    tick();
    checkOutput("t5_grant0", grant, 4'b0001);
    applyStimulus(4'b0011, 8'd2, 8'd2, 8'd0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("t5_hold", grant, 4'b0001);
    end
    checkOutput("t5_cnt_last", cnt_val, 5);
    tick();
    checkOutput("t5_done0", done, 4'b0001);
    checkOutput("t5_gap", grant, 0);
    req = 4'b0010;
    tick();
    checkOutput("t5_grant1", grant, 4'b0010);
    checkOutput("t5_done_clear", done, 0);
    tick();
    tick();
    checkOutput("t5_done1", done, 4'b0010);
    req = '0;
    tick();

`ifdef TIMER_ARB_PRIO_EN
    // Test 6: fixed priority keeps granting requester 1 over 3
    doReset();
    applyStimulus(4'b1010, 8'd1, 8'd1, 8'd1, 8'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t6_grant1", grant, 4'b0010);
      tick();
      checkOutput("t6_done1", done, 4'b0010);
    end
    req = 4'b1000;
    tick();
    checkOutput("t6_grant3", grant, 4'b1000);
    req = '0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_share_arb.md
Name: timer_share_arb

Overview:
- Shares one cycle counter between NUM_REQ requesters that each need a timed interval (LED blink phases, debounce windows, delays).
- Arbitrates pending requests round-robin and loads the winner's interval length.
- Holds grant for exactly that many sys_clk cycles, then pulses that requester's done and toggles a shared LED indicator.
- Sits between the counter/LED datapath and the modules that previously each owned a private counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 25, width of each interval length and of the internal counter.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held high until done or abort.
- req_len  in  NUM_REQ*CNT_W  interval length per requester; slice i = bits [i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot, high while that requester owns the counter.
- done  out  NUM_REQ  one-cycle pulse when that requester's interval completes.
- busy  out  1  high in COUNT or DONE state.
- cnt_val  out  CNT_W  current counter value, for debug.
- led_out  out  1  toggles on every completed interval; aborted intervals do not toggle it.

Behaviour:
Reset (async assert, sync release):
- state = IDLE; grant = 0; done = 0; busy = 0; cnt_val = 0; led_out = 0.
- Round-robin pointer = requester NUM_REQ-1, so requester 0 has highest priority first.

States: IDLE, COUNT, DONE. All outputs are registered.

IDLE:
- If req != 0, pick the winner: first set bit searching upward from (last winner + 1), wrapping modulo NUM_REQ.
- On that edge: grant = onehot(winner); len_q = winner's req_len slice, with 0 forced to 1; cnt = 0; state -> COUNT.
- If req == 0, stay in IDLE with outputs at 0.

COUNT:
- cnt increments by 1 each cycle.
- If req[winner] drops (sampled low): abort. grant = 0, cnt = 0, state -> IDLE. No done, no led toggle. Pointer still advances to winner.
- Else, when cnt == len_q-1: grant = 0, done[winner] = 1, led_out toggles, cnt = 0, state -> DONE.
- grant is therefore high for exactly len_q cycles. Example: len=5 gives grant high 5 cycles, done in the 6th cycle.

DONE:
- Lasts one cycle; done is high during it.
- Arbitration runs in this cycle exactly as in IDLE, excluding nothing; the requester that just finished may win again if its req is still high and it is next in rotation.
- With a pending request: state -> COUNT with the new grant on the next edge, so there is a 1-cycle gap between grants.
- Otherwise state -> IDLE.

Other rules:
- req_len is sampled only at grant; later changes are ignored until the next grant.
- Requests arriving during COUNT wait; there is no preemption.
- Pointer updates to the winner at each grant.
- Counter compare uses the full CNT_W width. len_q = 2^CNT_W-1 is legal; cnt never wraps because it stops at len_q-1.
- Reset mid-COUNT: grant and done drop immediately (async). led_out returns to 0.

Optional Feature:
TIMER_ARB_PRIO_EN
- Defined: fixed priority, lowest-index pending requester always wins; the round-robin pointer is not implemented.
- Undefined: round-robin as described above.
- All other timing, including the abort and DONE gap, is identical in both builds.

Test Plan (NUM_REQ=4, CNT_W=8):
1. Reset mid-count: reset released, then req=4'b0001 with len0=5 → grant=0001 for 5 cycles, done[0] pulse on the next cycle, led_out 0→1. Re-assert reset while a new interval is counting → all outputs 0 asynchronously.
2. Round-robin: req=4'b1111 held, all len=3 → grant order 0,1,2,3,0. One idle cycle between grants. done pulses in the same order. led_out toggles 5 times.
3. Abort: req[2] granted with len=10, req[2] dropped after 4 grant cycles → grant goes to 0 the next edge. No done[2], led_out unchanged, state returns to IDLE.
4. Zero and max length: len=0 → grant high exactly 1 cycle, then done. len=255 → grant high exactly 255 cycles, cnt_val peaks at 254, no wrap.
5. Late arrival and len change: req[1] rises while req[0] (len=6) is counting; len0 changed mid-interval → the interval is still 6 cycles. req[1] is granted on the edge after done[0].
6. With TIMER_ARB_PRIO_EN: req=4'b1010 held → requester 1 is granted repeatedly and requester 3 never is, until req[1] drops.
